// File: rtl/rom_load_ctrl.sv
// rom_load_ctrl: owns the shared ROM/RAM write port. Download bytes are queued in a small FIFO
// and written out under a valid/ready handshake. A work-RAM clear engine runs after each
// download and after power-up. The game core is held in reset until the clear and a settle
// delay have completed.
module rom_load_ctrl #(
    parameter int unsigned    AW        = 25,
    parameter int unsigned    DEPTH     = 4,
    parameter logic [AW-1:0]  CLR_BASE  = 25'h0_1_0000,
    parameter int unsigned    CLR_WORDS = 4096,
    parameter int unsigned    HOLD_CYC  = 64
) (
    input  logic          i_clk_sys,
    input  logic          i_reset,
    input  logic          i_dl_active,
    input  logic          i_dl_wr,
    input  logic [AW-1:0] i_dl_addr,
    input  logic [7:0]    i_dl_data,
    input  logic          i_wr_ready,
    output logic          o_wr_en,
    output logic [AW-1:0] o_wr_addr,
    output logic [7:0]    o_wr_data,
    output logic          o_wr_sel,
    output logic          o_core_reset,
    output logic          o_overflow,
    output logic          o_busy
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = (CLR_WORDS > 0) ? $clog2(CLR_WORDS + 1) : 1;
    localparam int unsigned HW = $clog2(HOLD_CYC + 1);

    typedef enum logic [2:0] {StIdle, StLoad, StDrain, StClear, StHold} state_e;

    state_e          r_state;
    logic            r_dl_prev;
    logic [AW+7:0]   r_mem [DEPTH];
    logic [PW:0]     r_wptr;
    logic [PW:0]     r_rptr;
    logic [CW-1:0]   r_clr_cnt;
    logic [HW-1:0]   r_hold_cnt;
    logic            r_overflow;
    logic            r_wr_en;
    logic [AW-1:0]   r_wr_addr;
    logic [7:0]      r_wr_data;
    logic            r_wr_sel;
    logic            r_core_reset;
    logic            r_busy;

    state_e          w_state_nxt;
    logic [CW-1:0]   w_clr_nxt;
    logic [HW-1:0]   w_hold_nxt;
    logic            w_wr_en_nxt;
    logic [AW-1:0]   w_wr_addr_nxt;
    logic [7:0]      w_wr_data_nxt;
    logic            w_wr_sel_nxt;

    logic            w_empty;
    logic            w_full;
    logic            w_xfer;
    logic            w_pop;
    logic            w_push_req;
    logic            w_push;
    logic            w_drop;
    logic            w_dl_rise;
    logic [AW+7:0]   w_head;
    logic [AW-1:0]   w_clr_addr;

    assign w_empty    = (r_wptr == r_rptr);
    assign w_full     = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
    assign w_xfer     = r_wr_en & i_wr_ready;
    // Only download writes consume a FIFO entry; clear writes advance clr_cnt instead.
    assign w_pop      = w_xfer & ~r_wr_sel;
    assign w_push_req = i_dl_wr & i_dl_active;
    assign w_push     = w_push_req & (~w_full | w_pop);
    assign w_drop     = w_push_req & w_full & ~w_pop;
    assign w_dl_rise  = i_dl_active & ~r_dl_prev;
    assign w_head     = r_mem[r_rptr[PW-1:0]];
    assign w_clr_addr = CLR_BASE + AW'(r_clr_cnt);

    // FIFO storage; validity is tracked by the pointers so the array needs no reset
    always_ff @(posedge i_clk_sys) begin
        if (w_push) begin
            r_mem[r_wptr[PW-1:0]] <= {i_dl_addr, i_dl_data};
        end
    end

    // Next-state and registered-output computation for the load/clear sequencer
    always_comb begin
        w_state_nxt   = r_state;
        w_clr_nxt     = r_clr_cnt;
        w_hold_nxt    = r_hold_cnt;
        w_wr_en_nxt   = r_wr_en;
        w_wr_addr_nxt = r_wr_addr;
        w_wr_data_nxt = r_wr_data;
        w_wr_sel_nxt  = r_wr_sel;

        unique case (r_state)
            StIdle: begin
                w_wr_en_nxt = 1'b0;
                if (w_dl_rise) begin
                    w_state_nxt = StLoad;
                end
            end
            StLoad, StDrain: begin
                // Drop wr_en for one cycle after every transfer, then present the next head.
                if (r_wr_en) begin
                    if (i_wr_ready) begin
                        w_wr_en_nxt = 1'b0;
                    end
                end else if (!w_empty) begin
                    w_wr_en_nxt   = 1'b1;
                    w_wr_addr_nxt = w_head[AW+7:8];
                    w_wr_data_nxt = w_head[7:0];
                    w_wr_sel_nxt  = 1'b0;
                end
                if (r_state == StLoad) begin
                    if (!i_dl_active) begin
                        w_state_nxt = StDrain;
                    end
                end else if (w_dl_rise) begin
                    w_state_nxt = StLoad;
                end else if (w_empty && !r_wr_en) begin
                    w_state_nxt = StClear;
                    w_clr_nxt   = '0;
                end
            end
            StClear: begin
                if (w_dl_rise) begin
                    // Withdraw any pending clear write; clearing restarts after the next drain.
                    w_state_nxt = StLoad;
                    w_wr_en_nxt = 1'b0;
                    w_clr_nxt   = '0;
                end else if (CLR_WORDS == 0) begin
                    w_state_nxt = StHold;
                    w_hold_nxt  = '0;
                end else if (r_wr_en) begin
                    if (i_wr_ready) begin
                        w_wr_en_nxt = 1'b0;
                        if (r_clr_cnt == CW'(CLR_WORDS - 1)) begin
                            w_state_nxt = StHold;
                            w_hold_nxt  = '0;
                        end else begin
                            w_clr_nxt = r_clr_cnt + 1'b1;
                        end
                    end
                end else begin
                    w_wr_en_nxt   = 1'b1;
                    w_wr_addr_nxt = w_clr_addr;
                    w_wr_data_nxt = 8'h00;
                    w_wr_sel_nxt  = 1'b1;
                end
            end
            StHold: begin
                w_wr_en_nxt = 1'b0;
                if (w_dl_rise) begin
                    w_state_nxt = StLoad;
                    w_clr_nxt   = '0;
                end else if (r_hold_cnt == HW'(HOLD_CYC - 1)) begin
                    w_state_nxt = StIdle;
                end else begin
                    w_hold_nxt = r_hold_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = StClear;
                w_wr_en_nxt = 1'b0;
                w_clr_nxt   = '0;
            end
        endcase
    end

    // State, FIFO pointers, counters and all registered outputs
    always_ff @(posedge i_clk_sys or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= StClear;
            r_dl_prev    <= 1'b0;
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_clr_cnt    <= '0;
            r_hold_cnt   <= '0;
            r_overflow   <= 1'b0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_wr_sel     <= 1'b0;
            r_core_reset <= 1'b1;
            r_busy       <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_dl_prev    <= i_dl_active;
            r_clr_cnt    <= w_clr_nxt;
            r_hold_cnt   <= w_hold_nxt;
            r_wr_en      <= w_wr_en_nxt;
            r_wr_addr    <= w_wr_addr_nxt;
            r_wr_data    <= w_wr_data_nxt;
            r_wr_sel     <= w_wr_sel_nxt;
            r_core_reset <= (w_state_nxt != StIdle);
            r_busy       <= (w_state_nxt != StIdle);
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            // A new download clears the sticky flag; a drop in that same cycle still counts.
            if (w_dl_rise) begin
                r_overflow <= w_drop;
            end else if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign o_wr_en      = r_wr_en;
    assign o_wr_addr    = r_wr_addr;
    assign o_wr_data    = r_wr_data;
    assign o_wr_sel     = r_wr_sel;
    assign o_core_reset = r_core_reset;
    assign o_overflow   = r_overflow;
    assign o_busy       = r_busy;

endmodule

// File: tb/tb_rom_load_ctrl.sv
// tb_rom_load_ctrl: scoreboard bench for rom_load_ctrl. Stimulus pushes the writes it expects
// onto a queue; a forked monitor pops and compares on every handshake.
module tb_rom_load_ctrl;

    localparam int unsigned    AW        = 25;
    localparam int unsigned    DEPTH     = 4;
    localparam logic [AW-1:0]  CLR_BASE  = 25'h0_1_0000;
    localparam int unsigned    CLR_WORDS = 4;
    localparam int unsigned    HOLD_CYC  = 3;
    localparam int             LIMIT     = 3000;

    typedef logic [AW+8:0] exp_t;  // {sel, addr, data}

    logic          clk;
    logic          rst;
    logic          dl_active;
    logic          dl_wr;
    logic [AW-1:0] dl_addr;
    logic [7:0]    dl_data;
    logic          wr_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          wr_sel;
    logic          core_reset;
    logic          overflow;
    logic          busy;

    exp_t exp_q[$];
    int   checks;
    int   failures;
    int   cyc;
    int   dl_xfers;
    int   clr_xfers;
    int   last_clr_cyc;

    rom_load_ctrl #(
        .AW        (AW),
        .DEPTH     (DEPTH),
        .CLR_BASE  (CLR_BASE),
        .CLR_WORDS (CLR_WORDS),
        .HOLD_CYC  (HOLD_CYC)
    ) u_dut (
        .i_clk_sys    (clk),
        .i_reset      (rst),
        .i_dl_active  (dl_active),
        .i_dl_wr      (dl_wr),
        .i_dl_addr    (dl_addr),
        .i_dl_data    (dl_data),
        .i_wr_ready   (wr_ready),
        .o_wr_en      (wr_en),
        .o_wr_addr    (wr_addr),
        .o_wr_data    (wr_data),
        .o_wr_sel     (wr_sel),
        .o_core_reset (core_reset),
        .o_overflow   (overflow),
        .o_busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_clears();
        for (int i = 0; i < int'(CLR_WORDS); i++) begin
            exp_q.push_back({1'b1, AW'(CLR_BASE + AW'(i)), 8'h00});
        end
    endtask

    task automatic push_byte(input logic [AW-1:0] a, input logic [7:0] d, input bit expected);
        dl_addr = a;
        dl_data = d;
        dl_wr   = 1'b1;
        if (expected) exp_q.push_back({1'b0, a, d});
        tick();
        dl_wr = 1'b0;
    endtask

    // Waits for release of core reset, then checks the settle time and that nothing is left over.
    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (core_reset && n < LIMIT) begin
            tick();
            n++;
        end
        check({name, "_idle_in_time"}, 64'(n < LIMIT), 1);
        check({name, "_hold_cycles"}, 64'(cyc - last_clr_cyc), 64'(HOLD_CYC + 1));
        check({name, "_busy"}, 64'(busy), 0);
        check({name, "_writes_left"}, 64'(exp_q.size()), 0);
    endtask

    task automatic monitor();
        bit   prev_stall;
        exp_t prev_val;
        exp_t e;
        prev_stall = 1'b0;
        prev_val   = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                // Download writes may never change or vanish while stalled.
                if (prev_stall) begin
                    check("stall_hold", {wr_en, wr_sel, wr_addr, wr_data}, {1'b1, prev_val});
                end
                if (wr_en && wr_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_write actual=%0h required=none",
                                 {wr_sel, wr_addr, wr_data});
                    end else begin
                        e = exp_q.pop_front();
                        check("write", {wr_sel, wr_addr, wr_data}, e);
                    end
                    if (wr_sel) begin
                        clr_xfers++;
                        last_clr_cyc = cyc;
                    end else begin
                        dl_xfers++;
                    end
                end
                prev_stall = wr_en && !wr_ready && !wr_sel;
                prev_val   = {wr_sel, wr_addr, wr_data};
            end
        end
    endtask

    initial begin
        int n;
        int acc;
        int dl_base;
        int clr_base;
        checks       = 0;
        failures     = 0;
        dl_xfers     = 0;
        clr_xfers    = 0;
        last_clr_cyc = 0;
        rst          = 1'b1;
        dl_active    = 1'b0;
        dl_wr        = 1'b0;
        dl_addr      = '0;
        dl_data      = '0;
        wr_ready     = 1'b1;
        fork
            monitor();
        join_none

        // Power-up: reset values, then clear, hold, release.
        #1;
        check("rst_wr_en", 64'(wr_en), 0);
        check("rst_core_reset", 64'(core_reset), 1);
        check("rst_busy", 64'(busy), 1);
        check("rst_overflow", 64'(overflow), 0);
        check("rst_port", {wr_sel, wr_addr, wr_data}, 0);
        tick();
        tick();
        expect_clears();
        rst = 1'b0;
        wait_idle("powerup");

        // Fixed download of 8 bytes spaced 4 cycles, with a latency check on the first.
        dl_active = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            push_byte(AW'(i), 8'hA0 + 8'(i), 1'b1);
            if (i == 0) begin
                check("lat_early", 64'(wr_en), 0);
                tick();
                check("lat_present", {wr_en, wr_sel, wr_addr, wr_data},
                      {1'b1, 1'b0, AW'(0), 8'hA0});
                tick();
                tick();
            end else begin
                repeat (3) tick();
            end
        end
        dl_active = 1'b0;
        expect_clears();
        wait_idle("dl8");
        check("dl8_overflow", 64'(overflow), 0);

        // A strobe without an active download must be ignored.
        push_byte(AW'(25'h1_FFFF), 8'h5A, 1'b0);
        tick();

        // Overflow: 6 back-to-back bytes into a stalled 4-entry FIFO.
        wr_ready  = 1'b0;
        dl_active = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) begin
            push_byte(AW'(25'h100 + i), 8'h30 + 8'(i), i < int'(DEPTH));
        end
        tick();
        check("ovf_set", 64'(overflow), 1);
        check("ovf_head", {wr_en, wr_sel, wr_addr, wr_data}, {1'b1, 1'b0, AW'(25'h100), 8'h30});
        repeat (5) tick();
        wr_ready  = 1'b1;
        dl_active = 1'b0;
        expect_clears();
        wait_idle("ovf");
        check("ovf_sticky", 64'(overflow), 1);

        // Push into a full FIFO in the same cycle as a pop.
        wr_ready  = 1'b0;
        dl_active = 1'b1;
        tick();
        for (int i = 0; i < int'(DEPTH); i++) begin
            push_byte(AW'(25'h200 + i), 8'(8'h60 + i), 1'b1);
        end
        n = 0;
        while (!wr_en && n < 20) begin
            tick();
            n++;
        end
        check("full_pop_presented", 64'(wr_en), 1);
        wr_ready = 1'b1;
        push_byte(AW'(25'h2FF), 8'h6F, 1'b1);
        repeat (2) tick();
        check("full_pop_overflow", 64'(overflow), 0);
        dl_active = 1'b0;
        expect_clears();
        wait_idle("fullpop");

        // Abort the clear at clr_cnt=2 with a new download.
        dl_active = 1'b1;
        tick();
        push_byte(AW'(25'h300), 8'h11, 1'b1);
        push_byte(AW'(25'h301), 8'h22, 1'b1);
        dl_active = 1'b0;
        exp_q.push_back({1'b1, CLR_BASE, 8'h00});
        exp_q.push_back({1'b1, AW'(CLR_BASE + 1), 8'h00});
        clr_base = clr_xfers;
        n = 0;
        while (clr_xfers < clr_base + 2 && n < 200) begin
            tick();
            n++;
        end
        check("abort_reach_cnt2", 64'(clr_xfers - clr_base), 2);
        wr_ready = 1'b0;
        tick();
        check("abort_pending", {wr_en, wr_sel, wr_addr}, {1'b1, 1'b1, AW'(CLR_BASE + 2)});
        dl_active = 1'b1;
        tick();
        check("abort_withdrawn", 64'(wr_en), 0);
        check("abort_core_reset", 64'(core_reset), 1);
        wr_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push_byte(AW'($urandom), 8'($urandom), 1'b1);
            tick();
        end
        dl_active = 1'b0;
        expect_clears();
        wait_idle("abort");

        // Randomized downloads with random target stalls.
        for (int r = 0; r < 3; r++) begin
            dl_active = 1'b1;
            tick();
            dl_base = dl_xfers;
            acc     = 0;
            repeat (40) begin
                wr_ready = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 1) == 1 && (acc - (dl_xfers - dl_base)) < int'(DEPTH)) begin
                    push_byte(AW'($urandom), 8'($urandom), 1'b1);
                    acc++;
                end else begin
                    tick();
                end
            end
            wr_ready  = 1'b1;
            dl_active = 1'b0;
            expect_clears();
            wait_idle($sformatf("rand%0d", r));
            check($sformatf("rand%0d_overflow", r), 64'(overflow), 0);
        end

        // Reset pulse mid-load with 3 bytes queued.
        wr_ready  = 1'b0;
        dl_active = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            push_byte(AW'(25'h400 + i), 8'(8'hC0 + i), 1'b0);
        end
        tick();
        check("midrst_presenting", 64'(wr_en), 1);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_wr_en", 64'(wr_en), 0);
        check("midrst_core_reset", 64'(core_reset), 1);
        check("midrst_busy", 64'(busy), 1);
        check("midrst_port", {wr_sel, wr_addr, wr_data}, 0);
        dl_active = 1'b0;
        wr_ready  = 1'b1;
        tick();
        tick();
        expect_clears();
        rst = 1'b0;
        wait_idle("midrst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rom_load_ctrl.md
Name: rom_load_ctrl

Overview:
- Owns the single shared ROM/RAM write port of the game core.
- Arbitrates that port between two sources: the HPS download byte stream (ioctl_*) and an internal work-RAM clear engine.
- Buffers download bytes in a small FIFO so the target can stall via wr_ready.
- Holds the game core in reset from power-up or download start until ROM load, RAM clear and a settle delay are complete.

Parameters:
- AW, 25, download/write address width.
- DEPTH, 4, FIFO entries; power of two, at least 2.
- CLR_BASE, 25'h0_1_0000, first address written by the clear engine.
- CLR_WORDS, 4096, bytes to clear; 0 skips the clear phase.
- HOLD_CYC, 64, clk_sys cycles core_reset stays high after clear; at least 1.

Ports:
- clk_sys, in, 1, system clock; all logic rising-edge.
- RESET, in, 1, asynchronous, active-high reset.
- dl_active, in, 1, download in progress (ioctl_download).
- dl_wr, in, 1, one-cycle byte strobe (ioctl_wr).
- dl_addr, in, AW, byte address (ioctl_addr).
- dl_data, in, 8, byte data (ioctl_dout).
- wr_ready, in, 1, target accepts the presented write this cycle.
- wr_en, out, 1, write request valid.
- wr_addr, out, AW, write address.
- wr_data, out, 8, write data.
- wr_sel, out, 1, 0 = ROM download write, 1 = RAM clear write.
- core_reset, out, 1, game core reset.
- overflow, out, 1, sticky: a download byte was dropped.
- busy, out, 1, state is not IDLE.

Behaviour:
- Reset is asynchronous and active-high. RESET asserts: state=CLEAR, clr_cnt=0, FIFO empty, overflow=0, hold_cnt=0, core_reset=1, busy=1, wr_en=0, wr_addr=0, wr_data=0, wr_sel=0.
- All outputs are registered.
- FIFO:
  - Push occurs on dl_wr when not full, or when full with a pop in the same cycle.
  - Push while full with no pop drops the byte and sets overflow.
  - Pointers are log2(DEPTH) bits wide plus one wrap bit; full and empty are derived from the wrap bit.
- Handshake:
  - A write transfers on any cycle where wr_en and wr_ready are both 1. The same cycle pops the FIFO or advances clr_cnt.
  - wr_addr, wr_data and wr_sel hold stable while wr_en=1 and wr_ready=0.
  - The next entry is presented on the cycle after the transfer, so the port carries at most one write every 2 cycles.
- Latency: a byte pushed into an empty FIFO appears on wr_en, wr_addr and wr_data 2 cycles after its dl_wr cycle.
- States:
  - IDLE: core_reset=0, wr_en=0. Rising edge of dl_active → LOAD.
  - LOAD: core_reset=1. Presents the FIFO head with wr_sel=0. When dl_active falls → DRAIN.
  - DRAIN: keeps presenting FIFO entries. FIFO empty and no write pending → CLEAR with clr_cnt=0. Rising edge of dl_active → LOAD, FIFO contents kept.
  - CLEAR: wr_addr=CLR_BASE+clr_cnt, wr_data=0, wr_sel=1. Each transfer increments clr_cnt. After the transfer at clr_cnt=CLR_WORDS-1 → HOLD with hold_cnt=0. If CLR_WORDS=0, go straight to HOLD.
  - HOLD: wr_en=0. hold_cnt counts up; at HOLD_CYC-1 → IDLE, and core_reset falls on that transition.
- dl_active rising edge in CLEAR or HOLD:
  - Abort the current phase and go to LOAD.
  - A pending clear write is withdrawn without transferring.
  - The clear restarts from clr_cnt=0 after the next DRAIN.
- The dl_active rising edge clears overflow. dl_wr in the same cycle is still accepted.
- dl_wr while dl_active=0 is ignored.
- Width rules:
  - clr_cnt is wide enough to hold CLR_WORDS.
  - CLR_BASE+clr_cnt is truncated to AW bits and wraps modulo 2^AW.
  - hold_cnt is wide enough to hold HOLD_CYC.
- Sequence after RESET deasserts: CLEAR, then HOLD, then IDLE. The core therefore sees a cleared RAM at power-up.

Test Plan:
1. Power-up, CLR_WORDS=4, HOLD_CYC=3, wr_ready=1 → 4 writes at addresses 0x10000..0x10003 with data 0 and wr_sel=1; core_reset falls 3 cycles after the last write; busy=0.
2. Download of 8 bytes (addr 0..7, data 0xA0..0xA7) spaced 4 cycles, wr_ready=1 → 8 writes in order with wr_sel=0, the first 2 cycles after its dl_wr; then clear, hold, release; overflow=0.
3. Back-to-back dl_wr for 6 cycles, DEPTH=4, wr_ready=0 → 4 bytes retained, overflow=1; after wr_ready=1 exactly bytes 0..3 are written; wr_addr/wr_data stable during the stall.
4. dl_active rises while clear is at clr_cnt=2 → clear abandoned, core_reset stays 1; after the new download drains, the clear restarts at 0x10000.
5. Push into a full FIFO on the same cycle as a pop → byte accepted, overflow stays 0, order preserved.
6. RESET pulse mid-LOAD with 3 bytes queued → FIFO emptied immediately (asynchronously), wr_en=0; after RESET deasserts the sequence restarts at CLEAR.
